vvalu_config_sequencer: RTL and testbench
=========================================

# vvalu_config_sequencer

Firmware configuration sequencer for the vector-vector ALU stage. Holds a host-writable shadow image of the ALU's per-chain firmware tables and, on a commit request, takes the ALU out of tracing, waits for its pipeline to drain, streams the image as a contiguous `configId`/`configData` byte burst, then returns control of `tracing` to upstream trace control. Sits between the host/debug register interface and the ALU's `tracing`, `configId` and `configData` inputs.

## Interface
- `MAX_CHAINS`, 4, number of chains; must match the ALU.
- `NUM_FIELDS`, 6, firmware tables per chain, in stream order: op, addr_rd, cond, cache, cache_addr, minicache.
- `TARGET_CONFIG_ID`, 0, configId value the target ALU answers to.
- `IDLE_CONFIG_ID`, 8'hFF, configId driven when not streaming; must differ from `TARGET_CONFIG_ID`.
- `DRAIN_CYCLES`, 3, consecutive quiet cycles on `alu_valid_out` required before streaming; minimum 1.
- `IMG_BYTES` (localparam) = `MAX_CHAINS*NUM_FIELDS`; `AW` = `$clog2(IMG_BYTES)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_wr_en` in 1: shadow byte write strobe.
- `cfg_wr_addr` in AW: shadow byte index; index = field*MAX_CHAINS + chain.
- `cfg_wr_data` in 8: shadow byte value.
- `commit_req` in 1: level request to load the shadow image into the ALU.
- `tracing_req` in 1: tracing enable from upstream trace control.
- `alu_valid_out` in 1: ALU `valid_out`, used for drain detection.
- `tracing` out 1: tracing enable to the ALU.
- `configId` out 8: to ALU.
- `configData` out 8: to ALU.
- `busy` out 1: high from commit acceptance until return to IDLE.
- `done` out 1: one-cycle pulse when the burst completes.
- `wr_dropped` out 1: sticky flag set by a write while `busy`; cleared on the next accepted commit.

## Operation
- Shadow image: `IMG_BYTES` x 8 registers, reset to 0. A write with `cfg_wr_addr >= IMG_BYTES` is ignored.
- A write is accepted only in IDLE. A write while `busy` is discarded and sets `wr_dropped`.
- FSM states: IDLE, DRAIN, STREAM, CLOSE.
- IDLE:
  - `tracing` = `tracing_req`, registered with one cycle of delay.
  - `configId` = `IDLE_CONFIG_ID`.
  - When `commit_req` is high, the commit is accepted: go to DRAIN, set `busy`, clear `wr_dropped`.
  - Simultaneous write and commit in IDLE: the write lands and is included in the burst.
- DRAIN:
  - `tracing` = 0.
  - The quiet counter increments when `alu_valid_out` = 0 and resets to 0 when it is 1.
  - When the counter reaches `DRAIN_CYCLES`, go to STREAM with byte index k = 0.
- STREAM:
  - Each cycle: `configId` = `TARGET_CONFIG_ID`, `configData` = shadow[k], k++.
  - Bytes are sent back-to-back, with no gaps. The ALU's internal byte counter depends on an uninterrupted match.
  - After k = `IMG_BYTES`-1 is sent, go to CLOSE.
- CLOSE:
  - One cycle with `configId` = `IDLE_CONFIG_ID` and `tracing` = 0, which resets the ALU byte counter.
  - `done` pulses this cycle. Next state is IDLE with `busy` cleared.
- `commit_req` held high after `done` starts a new commit on the IDLE cycle.
- `tracing_req` changes during DRAIN/STREAM/CLOSE are ignored. IDLE resamples it.
- Reset mid-burst: all outputs return to reset values immediately. The ALU is left partially configured, and the host must re-commit.

## Timing
- All outputs are registered.
- Reset values: `tracing` 0, `configId` `IDLE_CONFIG_ID`, `configData` 0, `busy` 0, `done` 0, `wr_dropped` 0.
- Commit sampled at edge T:
  - `busy` = 1 and `tracing` = 0 from T+1.
  - With a quiet ALU, the first STREAM byte appears at T+1+`DRAIN_CYCLES`.
  - Burst lasts `IMG_BYTES` cycles, followed by one CLOSE cycle.
  - Total with a quiet ALU: `DRAIN_CYCLES` + `IMG_BYTES` + 1 cycles of `busy`.
- `configData` is don't-care outside STREAM; it is held at the last value.

## Configuration
- `VVALU_CFG_READBACK_EN`:
  - Defined: adds input `cfg_rd_addr` [AW] and output `cfg_rd_data` [8]. `cfg_rd_data` = shadow[`cfg_rd_addr`], registered with 1-cycle latency, reset 0, reads 0 when out of range. Reads are allowed in any state.
  - Undefined: these ports and their logic are absent; everything else is identical.

## Test plan
- Defaults. Write shadow[i] = 8'h10+i for i = 0..23, `tracing_req` = 1, commit with a quiet ALU:
  - `tracing` falls one cycle after acceptance.
  - 3 drain cycles.
  - 24 consecutive bytes 8'h10..8'h27 with `configId` = 0.
  - One `configId` = FF cycle with `done` = 1.
  - `tracing` returns to 1 one cycle after IDLE.
- Drain restart: `alu_valid_out` = 1 on the 2nd drain cycle. The first byte is delayed until 3 fresh quiet cycles have elapsed.
- Write during STREAM to addr 5 with 8'hAA: `wr_dropped` = 1, shadow[5] is unchanged, and the next commit clears the flag.
- Same-cycle write (addr 0, 8'h55) and commit in IDLE: the first streamed byte is 8'h55.
- Reset asserted at byte 10: `configId` = FF, `busy` = 0, `tracing` = 0 immediately. After release the shadow is all zero and a commit streams 24 zero bytes.
- With `VVALU_CFG_READBACK_EN`: write addr 7 = 8'h3C, then read addr 7. `cfg_rd_data` = 8'h3C one cycle later; reading addr 30 returns 0.

Source files
------------

// File: rtl/vvalu_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vvalu_config_sequencer
// Description : Firmware configuration sequencer for the vector-vector ALU.
//               Holds a host-writable shadow image of the per-chain firmware
//               tables. On commit it drops tracing, waits for the ALU pipeline
//               to drain, then streams the image as a contiguous
//               configId/configData burst and closes with one idle-id cycle.
// Options     : VVALU_CFG_READBACK_EN - adds registered shadow readback port
//               (cfg_rd_addr / cfg_rd_data).
// Revision    : 1.0 - initial release
// ============================================================================
module vvalu_config_sequencer #(
    parameter int         MAX_CHAINS       = 4,
    parameter int         NUM_FIELDS       = 6,
    parameter logic [7:0] TARGET_CONFIG_ID = 8'h00,
    parameter logic [7:0] IDLE_CONFIG_ID   = 8'hFF,
    parameter int         DRAIN_CYCLES     = 3,
    localparam int        IMG_BYTES        = MAX_CHAINS * NUM_FIELDS,
    localparam int        AW               = $clog2(IMG_BYTES)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_wr_en,
    input  logic [AW-1:0] cfg_wr_addr,
    input  logic [7:0]    cfg_wr_data,
    input  logic          commit_req,
    input  logic          tracing_req,
    input  logic          alu_valid_out,
    output logic          tracing,
    output logic [7:0]    configId,
    output logic [7:0]    configData,
    output logic          busy,
    output logic          done,
    output logic          wr_dropped
`ifdef VVALU_CFG_READBACK_EN
    ,
    input  logic [AW-1:0] cfg_rd_addr,
    output logic [7:0]    cfg_rd_data
`endif
);

    // Quiet counter only has to reach DRAIN_CYCLES; byte index must reach IMG_BYTES.
    localparam int             DW       = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]  c_drain  = DW'(DRAIN_CYCLES);
    localparam logic [AW:0]    c_img    = (AW + 1)'(IMG_BYTES);
    localparam logic [AW:0]    c_k_one  = (AW + 1)'(1);
    localparam logic [DW-1:0]  c_q_one  = DW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_STREAM = 2'd2,
        S_CLOSE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state;
    logic [DW-1:0]   r_quiet;
    logic [DW-1:0]   w_quiet;
    logic [DW-1:0]   w_quiet_inc;
    logic [AW:0]     r_k;
    logic [AW:0]     w_k;
    logic [7:0]      r_shadow [IMG_BYTES];

    logic            r_tracing,     w_tracing;
    logic [7:0]      r_config_id,   w_config_id;
    logic [7:0]      r_config_data, w_config_data;
    logic            r_busy,        w_busy;
    logic            r_done,        w_done;
    logic            r_wr_dropped,  w_wr_dropped;
    logic            w_wr_accept;

    // Host writes only land while idle and in range; a same-cycle commit still sees them.
    assign w_wr_accept = (r_state == S_IDLE) && cfg_wr_en && ({1'b0, cfg_wr_addr} < c_img);
    assign w_quiet_inc = r_quiet + c_q_one;

    // Shadow image storage, cleared by reset so a re-commit after reset streams zeros.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < IMG_BYTES; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_wr_accept) begin
            r_shadow[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    // FSM state register plus drain counter and stream byte index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_quiet <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state;
            r_quiet <= w_quiet;
            r_k     <= w_k;
        end
    end

    // Next-state and next-output decode; outputs are computed one cycle ahead and registered.
    always_comb begin
        w_state       = r_state;
        w_quiet       = r_quiet;
        w_k           = r_k;
        w_tracing     = r_tracing;
        w_config_id   = IDLE_CONFIG_ID;
        w_config_data = r_config_data;
        w_busy        = r_busy;
        w_done        = 1'b0;
        w_wr_dropped  = r_wr_dropped;

        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (commit_req) begin
                    w_state      = S_DRAIN;
                    w_tracing    = 1'b0;
                    w_busy       = 1'b1;
                    w_wr_dropped = 1'b0;
                    w_quiet      = '0;
                end else begin
                    w_tracing = tracing_req;
                end
            end
            S_DRAIN: begin
                w_tracing = 1'b0;
                if (alu_valid_out) begin
                    w_quiet = '0;
                end else if (w_quiet_inc == c_drain) begin
                    // Drain satisfied: the first byte goes out on this same edge.
                    w_state       = S_STREAM;
                    w_quiet       = '0;
                    w_config_id   = TARGET_CONFIG_ID;
                    w_config_data = r_shadow[0];
                    w_k           = c_k_one;
                end else begin
                    w_quiet = w_quiet_inc;
                end
            end
            S_STREAM: begin
                w_tracing = 1'b0;
                if (r_k == c_img) begin
                    // Idle id for one cycle resets the ALU's byte counter.
                    w_state = S_CLOSE;
                    w_done  = 1'b1;
                end else begin
                    w_config_id   = TARGET_CONFIG_ID;
                    w_config_data = r_shadow[r_k[AW-1:0]];
                    w_k           = r_k + c_k_one;
                end
            end
            S_CLOSE: begin
                w_state   = S_IDLE;
                w_tracing = 1'b0;
                w_busy    = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Any write attempted while a commit is in flight is lost; flag it for the host.
        if ((r_state != S_IDLE) && cfg_wr_en) begin
            w_wr_dropped = 1'b1;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tracing     <= 1'b0;
            r_config_id   <= IDLE_CONFIG_ID;
            r_config_data <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_wr_dropped  <= 1'b0;
        end else begin
            r_tracing     <= w_tracing;
            r_config_id   <= w_config_id;
            r_config_data <= w_config_data;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_wr_dropped  <= w_wr_dropped;
        end
    end

    assign tracing    = r_tracing;
    assign configId   = r_config_id;
    assign configData = r_config_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign wr_dropped = r_wr_dropped;

`ifdef VVALU_CFG_READBACK_EN
    logic [7:0] r_rd_data;

    // Registered shadow readback, usable in any state; out-of-range reads return zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if ({1'b0, cfg_rd_addr} < c_img) begin
            r_rd_data <= r_shadow[cfg_rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign cfg_rd_data = r_rd_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vvalu_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vvalu_config_sequencer
// Description : Self-checking bench for vvalu_config_sequencer. A shadow-image
//               array and a drain-timing rule predict every burst; stimulus
//               includes random data, random ALU activity and tracing noise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vvalu_config_sequencer;

    localparam int         IMG   = 24;
    localparam int         D     = 3;
    localparam int         CAP   = 48;
    localparam logic [7:0] ID_T  = 8'h00;
    localparam logic [7:0] ID_I  = 8'hFF;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cfg_wr_en;
    logic [4:0] cfg_wr_addr;
    logic [7:0] cfg_wr_data;
    logic       commit_req;
    logic       tracing_req;
    logic       alu_valid_out;
    logic       tracing;
    logic [7:0] configId;
    logic [7:0] configData;
    logic       busy;
    logic       done;
    logic       wr_dropped;
`ifdef VVALU_CFG_READBACK_EN
    logic [4:0] cfg_rd_addr;
    logic [7:0] cfg_rd_data;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference shadow image.
    logic [7:0] model [IMG];

    // Per-cycle capture of one commit, cycle 0 = first cycle after acceptance.
    logic [7:0] cap_id   [CAP];
    logic [7:0] cap_data [CAP];
    logic       cap_busy [CAP];
    logic       cap_done [CAP];
    logic       cap_tr   [CAP];
    logic       cap_wd   [CAP];
    logic       cap_valid[CAP];

    vvalu_config_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data),
        .commit_req   (commit_req),
        .tracing_req  (tracing_req),
        .alu_valid_out(alu_valid_out),
        .tracing      (tracing),
        .configId     (configId),
        .configData   (configData),
        .busy         (busy),
        .done         (done),
        .wr_dropped   (wr_dropped)
`ifdef VVALU_CFG_READBACK_EN
        ,
        .cfg_rd_addr  (cfg_rd_addr),
        .cfg_rd_data  (cfg_rd_data)
`endif
    );

    always #5 clk = ~clk;

    // Host write while idle; the model follows the in-range ones.
    task automatic write_byte(input logic [4:0] addr, input logic [7:0] data);
        @(negedge clk);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = addr;
        cfg_wr_data = data;
        @(negedge clk);
        cfg_wr_en = 1'b0;
        if (addr < IMG) model[addr] = data;
    endtask

    // Issue one commit and record CAP cycles of outputs; no checking here.
    task automatic drive_commit(input logic [15:0] vpat, input int vlen, input logic trq,
                                input logic sc_en, input logic [4:0] sc_addr, input logic [7:0] sc_data,
                                input int mid_cyc, input logic [4:0] mid_addr, input logic [7:0] mid_data);
        @(negedge clk);
        commit_req  = 1'b1;
        tracing_req = trq;
        if (sc_en) begin
            cfg_wr_en   = 1'b1;
            cfg_wr_addr = sc_addr;
            cfg_wr_data = sc_data;
        end
        @(negedge clk);
        commit_req = 1'b0;
        cfg_wr_en  = 1'b0;
        for (int c = 0; c < CAP; c++) begin
            cap_id[c]   = configId;
            cap_data[c] = configData;
            cap_busy[c] = busy;
            cap_done[c] = done;
            cap_tr[c]   = tracing;
            cap_wd[c]   = wr_dropped;
            if (c < vlen)       cap_valid[c] = vpat[c];
            else if (c >= 24)   cap_valid[c] = 1'($urandom_range(0, 1));
            else                cap_valid[c] = 1'b0;
            alu_valid_out = cap_valid[c];
            tracing_req   = (c < 20) ? 1'($urandom_range(0, 1)) : trq;
            cfg_wr_en     = (c == mid_cyc);
            cfg_wr_addr   = mid_addr;
            cfg_wr_data   = mid_data;
            @(negedge clk);
        end
        alu_valid_out = 1'b0;
        cfg_wr_en     = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++; if (tracing    !== 1'b0) $display("FAIL reset_tracing got %b exp 0", tracing);     else n_pass++;
        n_checks++; if (configId   !== ID_I) $display("FAIL reset_configId got %h exp %h", configId, ID_I); else n_pass++;
        n_checks++; if (configData !== 8'h00) $display("FAIL reset_configData got %h exp 00", configData); else n_pass++;
        n_checks++; if (busy       !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy);           else n_pass++;
        n_checks++; if (done       !== 1'b0) $display("FAIL reset_done got %b exp 0", done);           else n_pass++;
        n_checks++; if (wr_dropped !== 1'b0) $display("FAIL reset_wr_dropped got %b exp 0", wr_dropped); else n_pass++;
    endtask

    // Full cycle-by-cycle check of one commit against the model.
    task automatic test_commit(input string name, input logic [15:0] vpat, input int vlen, input logic trq,
                               input logic sc_en, input logic [4:0] sc_addr, input logic [7:0] sc_data);
        int s;
        logic [7:0] e_id;
        logic       e_busy, e_done, e_tr;
        if (sc_en && sc_addr < IMG) model[sc_addr] = sc_data;
        drive_commit(vpat, vlen, trq, sc_en, sc_addr, sc_data, -1, 5'd0, 8'd0);
        // First byte needs D quiet samples after the last busy ALU cycle.
        s = D;
        for (int c = 0; c < s; c++) if (cap_valid[c]) s = c + 1 + D;
        n_checks++;
        if (cap_wd[0] !== 1'b0) $display("FAIL %s wr_dropped_clear got %b exp 0", name, cap_wd[0]); else n_pass++;
        for (int c = 0; c <= s + 26 && c < CAP; c++) begin
            e_id   = (c >= s && c < s + IMG) ? ID_T : ID_I;
            e_busy = (c <= s + IMG);
            e_done = (c == s + IMG);
            e_tr   = (c == s + IMG + 2) ? trq : 1'b0;
            n_checks++;
            if (cap_id[c] !== e_id) $display("FAIL %s configId cyc %0d got %h exp %h", name, c, cap_id[c], e_id); else n_pass++;
            n_checks++;
            if (cap_busy[c] !== e_busy) $display("FAIL %s busy cyc %0d got %b exp %b", name, c, cap_busy[c], e_busy); else n_pass++;
            n_checks++;
            if (cap_done[c] !== e_done) $display("FAIL %s done cyc %0d got %b exp %b", name, c, cap_done[c], e_done); else n_pass++;
            n_checks++;
            if (cap_tr[c] !== e_tr) $display("FAIL %s tracing cyc %0d got %b exp %b", name, c, cap_tr[c], e_tr); else n_pass++;
            if (c >= s && c < s + IMG) begin
                n_checks++;
                if (cap_data[c] !== model[c - s])
                    $display("FAIL %s configData byte %0d got %h exp %h", name, c - s, cap_data[c], model[c - s]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_defaults;
        for (int i = 0; i < IMG; i++) write_byte(5'(i), 8'h10 + 8'(i));
        @(negedge clk);
        tracing_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (tracing !== 1'b1) $display("FAIL idle_tracing got %b exp 1", tracing); else n_pass++;
        test_commit("defaults", 16'h0, 0, 1'b1, 1'b0, 5'd0, 8'd0);
        n_checks++; if (cap_data[D] !== 8'h10) $display("FAIL defaults_first got %h exp 10", cap_data[D]); else n_pass++;
        n_checks++; if (cap_data[D + 23] !== 8'h27) $display("FAIL defaults_last got %h exp 27", cap_data[D + 23]); else n_pass++;
    endtask

    task automatic test_drain_restart;
        test_commit("drain_restart", 16'h0002, 16, 1'b1, 1'b0, 5'd0, 8'd0);
        n_checks++; if (cap_id[4] !== ID_I) $display("FAIL drain_restart_early got %h exp %h", cap_id[4], ID_I); else n_pass++;
        n_checks++; if (cap_id[5] !== ID_T) $display("FAIL drain_restart_start got %h exp %h", cap_id[5], ID_T); else n_pass++;
    endtask

    task automatic test_wr_dropped;
        drive_commit(16'h0, 0, 1'b1, 1'b0, 5'd0, 8'd0, D + 10, 5'd5, 8'hAA);
        n_checks++; if (cap_wd[D + 10] !== 1'b0) $display("FAIL wr_dropped_before got %b exp 0", cap_wd[D + 10]); else n_pass++;
        n_checks++; if (cap_wd[D + 11] !== 1'b1) $display("FAIL wr_dropped_set got %b exp 1", cap_wd[D + 11]); else n_pass++;
        n_checks++; if (cap_wd[CAP - 1] !== 1'b1) $display("FAIL wr_dropped_sticky got %b exp 1", cap_wd[CAP - 1]); else n_pass++;
        test_commit("after_drop", 16'h0, 0, 1'b0, 1'b0, 5'd0, 8'd0);
        n_checks++; if (cap_data[D + 5] === 8'hAA) $display("FAIL dropped_write_landed got %h exp %h", cap_data[D + 5], model[5]); else n_pass++;
    endtask

    task automatic test_same_cycle;
        test_commit("same_cycle", 16'h0, 0, 1'b1, 1'b1, 5'd0, 8'h55);
        n_checks++; if (cap_data[D] !== 8'h55) $display("FAIL same_cycle_first got %h exp 55", cap_data[D]); else n_pass++;
    endtask

    // commit_req held through done: a second commit starts right from the IDLE cycle.
    task automatic test_back_to_back;
        int  l;
        logic e_busy, e_done;
        l = D + IMG + 1;
        @(negedge clk);
        commit_req = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 60; c++) begin
            e_busy = (c < l) || (c > l && c <= 2 * l);
            e_done = (c == l - 1) || (c == 2 * l);
            n_checks++;
            if (busy !== e_busy) $display("FAIL b2b busy cyc %0d got %b exp %b", c, busy, e_busy); else n_pass++;
            n_checks++;
            if (done !== e_done) $display("FAIL b2b done cyc %0d got %b exp %b", c, done, e_done); else n_pass++;
            if (c == 30) commit_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        logic [15:0] vp;
        for (int it = 0; it < 5; it++) begin
            for (int w = 0; w < 8; w++) write_byte(5'($urandom_range(0, 31)), 8'($urandom));
            vp = 16'($urandom) & 16'($urandom) & 16'($urandom);
            test_commit("random", vp, 16, 1'($urandom_range(0, 1)), 1'b0, 5'd0, 8'd0);
        end
    endtask

`ifdef VVALU_CFG_READBACK_EN
    task automatic test_readback;
        logic [4:0] a;
        write_byte(5'd7, 8'h3C);
        cfg_rd_addr = 5'd7;
        @(negedge clk);
        n_checks++; if (cfg_rd_data !== 8'h3C) $display("FAIL readback_7 got %h exp 3c", cfg_rd_data); else n_pass++;
        cfg_rd_addr = 5'd30;
        @(negedge clk);
        n_checks++; if (cfg_rd_data !== 8'h00) $display("FAIL readback_30 got %h exp 00", cfg_rd_data); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            a = 5'($urandom_range(0, 23));
            cfg_rd_addr = a;
            @(negedge clk);
            n_checks++;
            if (cfg_rd_data !== model[a]) $display("FAIL readback_rand addr %0d got %h exp %h", a, cfg_rd_data, model[a]); else n_pass++;
        end
    endtask
`endif

    task automatic test_reset_mid_burst;
        @(negedge clk);
        commit_req  = 1'b1;
        tracing_req = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
        repeat (D + 10) @(negedge clk);
        n_checks++; if (configId !== ID_T) $display("FAIL midreset_pre_id got %h exp %h", configId, ID_T); else n_pass++;
        n_checks++; if (configData !== model[10]) $display("FAIL midreset_pre_data got %h exp %h", configData, model[10]); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (configId !== ID_I) $display("FAIL midreset_id got %h exp %h", configId, ID_I); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL midreset_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (tracing !== 1'b0) $display("FAIL midreset_tracing got %b exp 0", tracing); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL midreset_done got %b exp 0", done); else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < IMG; i++) model[i] = 8'h00;
        test_commit("post_reset_zero", 16'h0, 0, 1'b1, 1'b0, 5'd0, 8'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        cfg_wr_en     = 1'b0;
        cfg_wr_addr   = '0;
        cfg_wr_data   = '0;
        commit_req    = 1'b0;
        tracing_req   = 1'b0;
        alu_valid_out = 1'b0;
`ifdef VVALU_CFG_READBACK_EN
        cfg_rd_addr   = '0;
`endif
        for (int i = 0; i < IMG; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        test_reset;
        reset_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_defaults;
        test_drain_restart;
        test_wr_dropped;
        test_same_cycle;
        test_back_to_back;
        test_random;
`ifdef VVALU_CFG_READBACK_EN
        test_readback;
`endif
        test_reset_mid_burst;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
